// File: rtl/exp_req_ctrl.sv
// Request side of the CP0 exception interface: synchronizes raw event lines and latches them as pending.
// Presents one event at a time, highest index first, and holds it until acknowledged and serviced.
module exp_req_ctrl #(
    parameter int NSRC        = 3,
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NSRC-1:0]  irq_in,
    input  logic             exp_ack,
    input  logic             is_eret,
    input  logic             exp_block,
    output logic [NSRC-1:0]  ExpSrc,
    output logic [NSRC-1:0]  pending,
    output logic [NSRC-1:0]  in_service,
    output logic             timeout,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int PW = $clog2(NSRC + 1);
    localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t            state, state_n;
    logic [NSRC-1:0]   sync_p [SYNC_STAGES];
    logic [NSRC-1:0]   s_d;
    logic [NSRC-1:0]   rise, clr, lost;
    logic [TW-1:0]     tcnt, tcnt_n;
    logic [NSRC-1:0]   expsrc_n, insvc_n;
    logic              timeout_n;

    function automatic logic [NSRC-1:0] pick_highest(input logic [NSRC-1:0] v);
        logic [NSRC-1:0] r;
        r = '0;
        for (int i = 0; i < NSRC; i++)
            if (v[i]) r = NSRC'(1) << i;
        return r;
    endfunction

    function automatic logic [PW-1:0] count_ones(input logic [NSRC-1:0] v);
        logic [PW-1:0] c;
        c = '0;
        for (int i = 0; i < NSRC; i++)
            c = c + PW'(v[i]);
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [PW-1:0] b);
        logic [SW-1:0] sum;
        sum = SW'(a) + SW'(b);
        if (sum > SW'({CNT_W{1'b1}}))
            return {CNT_W{1'b1}};
        return sum[CNT_W-1:0];
    endfunction

    // Synchronizer chain and edge register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < SYNC_STAGES; k++)
                sync_p[k] <= '0;
            s_d <= '0;
        end else begin
            sync_p[0] <= irq_in;
            for (int k = 1; k < SYNC_STAGES; k++)
                sync_p[k] <= sync_p[k-1];
            s_d <= sync_p[SYNC_STAGES-1];
        end
    end

    // A new edge on the source being acknowledged re-arms it rather than counting as a drop
    assign rise = sync_p[SYNC_STAGES-1] & ~s_d;
    assign clr  = (state == REQ && exp_ack) ? ExpSrc : '0;
    assign lost = rise & pending & ~clr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending  <= '0;
            drop_cnt <= '0;
        end else begin
            pending  <= (pending & ~clr) | rise;
            drop_cnt <= sat_add(drop_cnt, count_ones(lost));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ExpSrc     <= '0;
            in_service <= '0;
            tcnt       <= '0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_n;
            ExpSrc     <= expsrc_n;
            in_service <= insvc_n;
            tcnt       <= tcnt_n;
            timeout    <= timeout_n;
        end
    end

    // The request stays fixed while in REQ; exp_block only gates leaving IDLE
    always_comb begin
        state_n   = state;
        expsrc_n  = ExpSrc;
        insvc_n   = in_service;
        tcnt_n    = tcnt;
        timeout_n = timeout;
        case (state)
            IDLE: begin
                if ((|pending) && !exp_block) begin
                    expsrc_n = pick_highest(pending);
                    tcnt_n   = '0;
                    state_n  = REQ;
                end
            end
            REQ: begin
                if (exp_ack) begin
                    insvc_n  = ExpSrc;
                    expsrc_n = '0;
                    state_n  = SERVICE;
                end else if (tcnt == TW'(ACK_TIMEOUT - 1)) begin
                    expsrc_n  = '0;
                    timeout_n = 1'b1;
                    state_n   = IDLE;
                end else begin
                    tcnt_n = tcnt + TW'(1);
                end
            end
            SERVICE: begin
                if (is_eret) begin
                    insvc_n = '0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
